// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority per bit, optional parity, 1/2 stop bits,
// one-entry valid/ready holding register with overrun pulse. Optional break detect: UART_RX_BREAK_DET_EN.
module uart_rx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescaler,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP_TWO,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      Parity_Error,
    output logic                      Stop_Error,
    output logic                      Overrun,
`ifdef UART_RX_BREAK_DET_EN
    output logic                      break_det,
`endif
    input  logic                      data_ready
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int BW = $clog2(DW);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_BRK_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [PW-1:0] edge_q, edge_d, p_q, p_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          par_en_q, par_en_d, par_typ_q, par_typ_d, stop_two_q, stop_two_d;
    logic          s0_q, s0_d, s1_q, s1_d;
    logic [DW-1:0] shift_q, shift_d, data_q, data_d;
    logic          par_err_q, par_err_d, stop_err_q, stop_err_d;
    logic          valid_q, valid_d, perr_q, perr_d, serr_q, serr_d, ovr_q, ovr_d;
`ifdef UART_RX_BREAK_DET_EN
    logic          any_one_q, any_one_d, brk_q, brk_d, is_break;
`endif

    logic          rx, maj, at_sample, bit_end, frame_done, commit, fin_stop;
    logic [PW-1:0] p_even, p_eff, half;

    assign rx        = sync_q[1];
    assign p_even    = {prescaler[PW-1:1], 1'b0};
    assign p_eff     = (p_even < PW'(4)) ? PW'(4) : p_even;
    assign half      = p_q >> 1;
    assign at_sample = (edge_q == half + PW'(1));
    assign bit_end   = (edge_q == p_q - PW'(1));
    // Third sample is the live synchroniser output; the first two were captured earlier.
    assign maj       = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
    assign fin_stop  = stop_err_q | ~maj;
`ifdef UART_RX_BREAK_DET_EN
    assign is_break  = ~any_one_q & ~maj;
`endif

    // NOTE: every _d gets its hold value before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        edge_d     = bit_end ? '0 : edge_q + PW'(1);
        p_d        = p_q;
        bit_d      = bit_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop_two_d = stop_two_q;
        s0_d       = (edge_q == half - PW'(1)) ? rx : s0_q;
        s1_d       = (edge_q == half) ? rx : s1_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        ovr_d      = 1'b0;
        frame_done = 1'b0;
        commit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                edge_d = '0;
                if (!rx && rx_prev_q) begin
                    state_d    = S_START;
                    p_d        = p_eff;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    stop_two_d = STOP_TWO;
                    bit_d      = '0;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            S_START: begin
                if (at_sample && maj)
                    state_d = S_IDLE;
                else if (bit_end)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (at_sample)
                    shift_d = {maj, shift_q[DW-1:1]};
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (at_sample)
                    par_err_d = (^shift_q) ^ par_typ_q ^ maj;
                if (bit_end)
                    state_d = S_STOP;
            end
            S_STOP: begin
                if (at_sample) begin
                    stop_err_d = fin_stop;
                    frame_done = !stop_two_q;
                end
                if (bit_end)
                    state_d = S_STOP2;
            end
            S_STOP2: begin
                if (at_sample)
                    frame_done = 1'b1;
            end
            S_BRK_WAIT: begin
                edge_d = '0;
                if (rx)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_RX_BREAK_DET_EN
        any_one_d = any_one_q;
        brk_d     = 1'b0;
        if (state_q == S_IDLE)
            any_one_d = 1'b0;
        else if (at_sample && maj && state_q != S_START)
            any_one_d = 1'b1;
        if (frame_done) begin
            if (is_break) begin
                brk_d   = 1'b1;
                state_d = S_BRK_WAIT;
            end else begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
        end
`else
        if (frame_done) begin
            commit  = 1'b1;
            state_d = S_IDLE;
        end
`endif

        // Commit at the last stop sample point; a full register with no taker drops the new frame.
        if (commit) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                perr_d  = par_err_q;
                serr_d  = fin_stop;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            edge_q     <= '0;
            p_q        <= PW'(4);
            bit_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop_two_q <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            any_one_q  <= 1'b0;
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], RX_IN};
            rx_prev_q  <= rx;
            edge_q     <= edge_d;
            p_q        <= p_d;
            bit_q      <= bit_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop_two_q <= stop_two_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
            any_one_q  <= any_one_d;
            brk_q      <= brk_d;
`endif
        end
    end

    assign P_DATA       = data_q;
    assign data_valid   = valid_q;
    assign Parity_Error = perr_q;
    assign Stop_Error   = serr_q;
    assign Overrun      = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
    assign break_det    = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8-bit and a 9-bit instance, hand-computed expectations.
module tb_uart_rx_param;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic [5:0] prescaler;
    logic       par_en, par_typ, stop_two;
    logic       rdy_a, rdy_b;
    logic [7:0] pd_a;
    logic [8:0] pd_b;
    logic       dv_a, pe_a, se_a, ov_a;
    logic       dv_b, pe_b, se_b, ov_b;
`ifdef UART_RX_BREAK_DET_EN
    logic       bk_a, bk_b;
`endif

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) u8 (
        .clk(clk), .reset(reset), .RX_IN(rx_a), .prescaler(prescaler),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP_TWO(stop_two),
        .P_DATA(pd_a), .data_valid(dv_a), .Parity_Error(pe_a), .Stop_Error(se_a),
        .Overrun(ov_a),
`ifdef UART_RX_BREAK_DET_EN
        .break_det(bk_a),
`endif
        .data_ready(rdy_a)
    );

    uart_rx_param #(.DATA_WIDTH(9), .PRESCALE_WIDTH(6)) u9 (
        .clk(clk), .reset(reset), .RX_IN(rx_b), .prescaler(prescaler),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP_TWO(stop_two),
        .P_DATA(pd_b), .data_valid(dv_b), .Parity_Error(pe_b), .Stop_Error(se_b),
        .Overrun(ov_b),
`ifdef UART_RX_BREAK_DET_EN
        .break_det(bk_b),
`endif
        .data_ready(rdy_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0_a, t0_b;
    int rise_a = 0, rise_b = 0, rise_cyc_a = 0, rise_cyc_b = 0, ovr_a = 0, brk_a = 0;
    logic [7:0] cap_a;
    logic [8:0] cap_b;
    logic cpe_a, cse_a, cpe_b, cse_b;
    logic dva_prev = 1'b0, dvb_prev = 1'b0;
    int r, o, b;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture each rising edge of data_valid together with the frame it presents.
    always @(negedge clk) begin
        if (dv_a && !dva_prev) begin
            rise_a++; rise_cyc_a = cyc; cap_a = pd_a; cpe_a = pe_a; cse_a = se_a;
        end
        dva_prev = dv_a;
        if (dv_b && !dvb_prev) begin
            rise_b++; rise_cyc_b = cyc; cap_b = pd_b; cpe_b = pe_b; cse_b = se_b;
        end
        dvb_prev = dv_b;
        if (ov_a) ovr_a++;
`ifdef UART_RX_BREAK_DET_EN
        if (bk_a) brk_a++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] frame(input logic [8:0] d, input int dw, input bit pe,
                                          input bit pb, input bit s1, input bit s2, input bit two);
        logic [15:0] f;
        int k;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < dw; i++) f[1+i] = d[i];
        k = 1 + dw;
        if (pe) begin f[k] = pb; k++; end
        f[k] = s1;
        k++;
        if (two) f[k] = s2;
        return f;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_a(input logic [15:0] bits, input int n, input int p);
        t0_a = cyc + 1;
        for (int i = 0; i < n; i++) begin
            rx_a = bits[i];
            repeat (p) @(negedge clk);
        end
        rx_a = 1'b1;
    endtask

    task automatic send_b(input logic [15:0] bits, input int n, input int p);
        t0_b = cyc + 1;
        for (int i = 0; i < n; i++) begin
            rx_b = bits[i];
            repeat (p) @(negedge clk);
        end
        rx_b = 1'b1;
    endtask

    initial begin
        reset = 1'b1; prescaler = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop_two = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b1;
        idle(3);
        check("rst_pdata", pd_a, 8'h00);
        check("rst_valid", dv_a, 1'b0);
        check("rst_perr", pe_a, 1'b0);
        check("rst_serr", se_a, 1'b0);
        check("rst_ovr", ov_a, 1'b0);
        reset = 1'b0;
        idle(5);

        // P=8, 8N1, 0xBA
        r = rise_a;
        send_a(frame(9'h0BA, 8, 0, 0, 1, 1, 0), 10, 8);
        idle(4);
        check("t1_count", rise_a - r, 1);
        check("t1_latency", rise_cyc_a - t0_a, 80);
        check("t1_data", cap_a, 8'hBA);
        check("t1_perr", cpe_a, 1'b0);
        check("t1_serr", cse_a, 1'b0);
        check("t1_valid_drop", dv_a, 1'b0);

        // P=16, even parity, 0x27 with parity bit 1 -> error
        prescaler = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        r = rise_a;
        send_a(frame(9'h027, 8, 1, 1, 1, 1, 0), 11, 16);
        idle(4);
        check("t2_count", rise_a - r, 1);
        check("t2_data", cap_a, 8'h27);
        check("t2_perr", cpe_a, 1'b1);
        check("t2_serr", cse_a, 1'b0);

        // Odd parity, odd prescaler 17 behaves as P=16
        prescaler = 6'd17; par_typ = 1'b1;
        r = rise_a;
        send_a(frame(9'h027, 8, 1, 1, 1, 1, 0), 11, 16);
        idle(4);
        check("t2o_count", rise_a - r, 1);
        check("t2o_latency", rise_cyc_a - t0_a, 172);
        check("t2o_data", cap_a, 8'h27);
        check("t2o_perr", cpe_a, 1'b0);

        // 9-bit instance, P=32, two stop bits, second one 0
        prescaler = 6'd32; par_en = 1'b0; par_typ = 1'b0; stop_two = 1'b1;
        r = rise_b;
        send_b(frame(9'h1A5, 9, 0, 0, 1, 0, 1), 12, 32);
        idle(4);
        check("t3_count", rise_b - r, 1);
        check("t3_latency", rise_cyc_b - t0_b, 372);
        check("t3_data", cap_b, 9'h1A5);
        check("t3_serr", cse_b, 1'b1);
        check("t3_perr", cpe_b, 1'b0);

        // Start glitch of P/2-1 cycles, then 0x55 with config changed mid-frame
        prescaler = 6'd16; stop_two = 1'b0;
        idle(4);
        r = rise_a;
        rx_a = 1'b0;
        idle(7);
        rx_a = 1'b1;
        idle(64);
        check("t4_glitch_none", rise_a - r, 0);
        fork
            send_a(frame(9'h055, 8, 0, 0, 1, 1, 0), 10, 16);
            begin
                idle(30);
                prescaler = 6'd40; par_en = 1'b1; stop_two = 1'b1; par_typ = 1'b1;
            end
        join
        idle(4);
        check("t4_count", rise_a - r, 1);
        check("t4_latency", rise_cyc_a - t0_a, 156);
        check("t4_data", cap_a, 8'h55);
        check("t4_perr", cpe_a, 1'b0);
        check("t4_serr", cse_a, 1'b0);

        // Prescaler below 4 clamps to P=4
        prescaler = 6'd1; par_en = 1'b0; stop_two = 1'b0; par_typ = 1'b0;
        idle(8);
        r = rise_a;
        send_a(frame(9'h096, 8, 0, 0, 1, 1, 0), 10, 4);
        idle(4);
        check("t5_count", rise_a - r, 1);
        check("t5_latency", rise_cyc_a - t0_a, 42);
        check("t5_data", cap_a, 8'h96);

        // Overrun: two back-to-back frames with no consumer
        prescaler = 6'd8; rdy_a = 1'b0;
        idle(8);
        r = rise_a; o = ovr_a;
        send_a(frame(9'h011, 8, 0, 0, 1, 1, 0), 10, 8);
        send_a(frame(9'h022, 8, 0, 0, 1, 1, 0), 10, 8);
        idle(4);
        check("t6_count", rise_a - r, 1);
        check("t6_valid_held", dv_a, 1'b1);
        check("t6_data_held", pd_a, 8'h11);
        check("t6_overrun_pulses", ovr_a - o, 1);
        rdy_a = 1'b1;
        idle(1);
        check("t6_valid_fall", dv_a, 1'b0);

        // Held frame with bad stop, then reset in the middle of the next frame
        rdy_a = 1'b0;
        send_a(frame(9'h0A7, 8, 0, 0, 0, 1, 0), 10, 8);
        idle(8);
        check("t7_held_data", pd_a, 8'hA7);
        check("t7_held_serr", se_a, 1'b1);
        rx_a = 1'b0;
        idle(8);
        rx_a = 1'b1;
        idle(12);
        reset = 1'b1;
        #1;
        check("t7_rst_pdata", pd_a, 8'h00);
        check("t7_rst_valid", dv_a, 1'b0);
        check("t7_rst_serr", se_a, 1'b0);
        check("t7_rst_perr", pe_a, 1'b0);
        check("t7_rst_ovr", ov_a, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        rdy_a = 1'b1;
        idle(20);
        r = rise_a;
        send_a(frame(9'h03C, 8, 0, 0, 1, 1, 0), 10, 8);
        idle(4);
        check("t7_count", rise_a - r, 1);
        check("t7_latency", rise_cyc_a - t0_a, 80);
        check("t7_data", cap_a, 8'h3C);
        check("t7_serr", cse_a, 1'b0);

        // Line held low for 20 bit times
        r = rise_a; b = brk_a;
        rx_a = 1'b0;
        idle(160);
        rx_a = 1'b1;
        idle(16);
`ifdef UART_RX_BREAK_DET_EN
        check("t8_no_delivery", rise_a - r, 0);
        check("t8_break_pulses", brk_a - b, 1);
`else
        check("t8_count", rise_a - r, 1);
        check("t8_data", cap_a, 8'h00);
        check("t8_serr", cse_a, 1'b1);
        check("t8_perr", cpe_a, 1'b0);
`endif
        r = rise_a;
        send_a(frame(9'h0C3, 8, 0, 0, 1, 1, 0), 10, 8);
        idle(4);
        check("t8_after_count", rise_a - r, 1);
        check("t8_after_data", cap_a, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
